// File: rtl/machine_pkg.sv
// Shared definitions for the machine line parser and the compute units it feeds:
// ASCII tokens, decoder states and the wiring bitmask type.
package machine_pkg;

  localparam int DEF_WIRING_WIDTH   = 16;
  localparam int DEF_BUTTON_WIRINGS = 16;

  localparam logic [7:0] CHAR_LBRACKET = 8'h5B;
  localparam logic [7:0] CHAR_RBRACKET = 8'h5D;
  localparam logic [7:0] CHAR_HASH     = 8'h23;
  localparam logic [7:0] CHAR_DOT      = 8'h2E;
  localparam logic [7:0] CHAR_LPAREN   = 8'h28;
  localparam logic [7:0] CHAR_COMMA    = 8'h2C;
  localparam logic [7:0] CHAR_RPAREN   = 8'h29;
  localparam logic [7:0] CHAR_LBRACE   = 8'h7B;
  localparam logic [7:0] CHAR_RBRACE   = 8'h7D;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [7:0] CHAR_0        = 8'h30;
  localparam logic [7:0] CHAR_9        = 8'h39;

  typedef enum logic [2:0] {
    ST_LINE_START,
    ST_DIAGRAM,
    ST_BETWEEN,
    ST_BUTTON,
    ST_JOLTAGE,
    ST_ERR_SKIP
  } decoder_state_t;

  typedef logic [DEF_WIRING_WIDTH-1:0] wiring_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHAR_0) && (c <= CHAR_9);
  endfunction

endpackage

// File: rtl/ascii_index_accumulator.sv
// Decimal accumulator for button indices: value = value*10 + digit, saturating at 255.
// clear and digit in the same cycle start a fresh number with that digit.
module ascii_index_accumulator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [7:0] value
);

  logic [7:0]  base;
  logic [11:0] wide;
  logic [7:0]  value_next;

  always_comb begin
    base       = clear ? 8'd0 : value;
    wide       = ({4'd0, base} * 12'd10) + {8'd0, digit};
    value_next = base;
    if (digit_valid) begin
      value_next = (wide > 12'd255) ? 8'd255 : wide[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'd0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/machine_line_decoder.sv
// Parses ASCII machine lines into wiring bitmask strobes (diagram first, then one per button group)
// plus end-of-line / end-of-file markers; strobes are registered one cycle after the closing byte.
module machine_line_decoder
  import machine_pkg::*;
#(
  parameter int MAX_WIRING_WIDTH   = DEF_WIRING_WIDTH,
  parameter int MAX_BUTTON_WIRINGS = DEF_BUTTON_WIRINGS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inbound_valid,
  input  logic [7:0]                  inbound_data,
  input  logic                        inbound_eof,
  output logic                        end_of_file,
  output logic                        end_of_line,
  output logic                        wiring_valid,
  output logic [MAX_WIRING_WIDTH-1:0] wiring_data,
  output logic                        parse_error
);

  localparam int POS_W = $clog2(MAX_WIRING_WIDTH + 1);
  localparam int CNT_W = $clog2(MAX_BUTTON_WIRINGS + 1);
  localparam logic [MAX_WIRING_WIDTH-1:0] BIT0 = (MAX_WIRING_WIDTH)'(1);

  decoder_state_t              state, state_n;
  logic [POS_W-1:0]            pos, pos_n;
  logic [CNT_W-1:0]            btn_cnt, btn_cnt_n;
  logic [MAX_WIRING_WIDTH-1:0] diag, diag_n;
  logic [MAX_WIRING_WIDTH-1:0] bits, bits_n;
  logic                        have_digit, have_digit_n;

  logic                        take;
  logic                        acc_clear, acc_digit;
  logic [7:0]                  acc_value;
  logic                        pos_ok, idx_ok, cnt_ok;
  logic [MAX_WIRING_WIDTH-1:0] pos_mask, idx_mask;
  logic                        emit_wiring, emit_eol, err;
  logic [MAX_WIRING_WIDTH-1:0] emit_data;

  ascii_index_accumulator u_index (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (acc_clear),
    .digit_valid (acc_digit),
    .digit       (inbound_data[3:0]),
    .value       (acc_value)
  );

  // Carriage returns are invisible to the parser and nothing is consumed once the file has ended.
  assign take     = inbound_valid && !end_of_file && (inbound_data != CHAR_CR);
  assign pos_ok   = pos < POS_W'(MAX_WIRING_WIDTH);
  assign idx_ok   = acc_value < 8'(MAX_WIRING_WIDTH);
  assign cnt_ok   = btn_cnt < CNT_W'(MAX_BUTTON_WIRINGS);
  assign pos_mask = BIT0 << pos;
  assign idx_mask = BIT0 << acc_value;

  always_comb begin
    state_n      = state;
    pos_n        = pos;
    btn_cnt_n    = btn_cnt;
    diag_n       = diag;
    bits_n       = bits;
    have_digit_n = have_digit;
    acc_clear    = 1'b0;
    acc_digit    = 1'b0;
    emit_wiring  = 1'b0;
    emit_eol     = 1'b0;
    emit_data    = '0;
    err          = 1'b0;

    if (take) begin
      case (state)
        ST_LINE_START: begin
          if (inbound_data == CHAR_LBRACKET) begin
            state_n   = ST_DIAGRAM;
            pos_n     = '0;
            btn_cnt_n = '0;
            diag_n    = '0;
          end else if (inbound_data != CHAR_LF) begin
            err = 1'b1;
          end
        end

        ST_DIAGRAM: begin
          if ((inbound_data == CHAR_DOT) || (inbound_data == CHAR_HASH)) begin
            if (!pos_ok) begin
              err = 1'b1;
            end else begin
              if (inbound_data == CHAR_HASH) begin
                diag_n = diag | pos_mask;
              end
              pos_n = pos + POS_W'(1);
            end
          end else if (inbound_data == CHAR_RBRACKET) begin
            emit_wiring = 1'b1;
            emit_data   = diag;
            state_n     = ST_BETWEEN;
          end else begin
            err = 1'b1;
          end
        end

        ST_BETWEEN: begin
          if (inbound_data == CHAR_LPAREN) begin
            if (!cnt_ok) begin
              err = 1'b1;
            end else begin
              state_n      = ST_BUTTON;
              bits_n       = '0;
              have_digit_n = 1'b0;
              acc_clear    = 1'b1;
            end
          end else if (inbound_data == CHAR_LBRACE) begin
            state_n = ST_JOLTAGE;
          end else if (inbound_data == CHAR_LF) begin
            emit_eol = 1'b1;
            state_n  = ST_LINE_START;
          end else if (inbound_data != CHAR_SPACE) begin
            err = 1'b1;
          end
        end

        ST_BUTTON: begin
          if (is_digit(inbound_data)) begin
            acc_digit    = 1'b1;
            have_digit_n = 1'b1;
          end else if ((inbound_data == CHAR_COMMA) || (inbound_data == CHAR_RPAREN)) begin
            // An empty slot or an out-of-range index poisons the line before any bit is set.
            if (!have_digit || !idx_ok) begin
              err = 1'b1;
            end else begin
              bits_n       = bits | idx_mask;
              have_digit_n = 1'b0;
              acc_clear    = 1'b1;
              if (inbound_data == CHAR_RPAREN) begin
                emit_wiring = 1'b1;
                emit_data   = bits | idx_mask;
                btn_cnt_n   = btn_cnt + CNT_W'(1);
                state_n     = ST_BETWEEN;
              end
            end
          end else begin
            err = 1'b1;
          end
        end

        ST_JOLTAGE: begin
          if (inbound_data == CHAR_RBRACE) begin
            state_n = ST_BETWEEN;
          end
        end

        ST_ERR_SKIP: begin
          if (inbound_data == CHAR_LF) begin
            state_n = ST_LINE_START;
          end
        end

        default: begin
          state_n = ST_LINE_START;
        end
      endcase

      // A newline that is itself unexpected still terminates the line, so resync immediately.
      if (err) begin
        state_n = (inbound_data == CHAR_LF) ? ST_LINE_START : ST_ERR_SKIP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LINE_START;
      pos          <= '0;
      btn_cnt      <= '0;
      diag         <= '0;
      bits         <= '0;
      have_digit   <= 1'b0;
      wiring_valid <= 1'b0;
      wiring_data  <= '0;
      end_of_line  <= 1'b0;
      parse_error  <= 1'b0;
      end_of_file  <= 1'b0;
    end else begin
      state        <= state_n;
      pos          <= pos_n;
      btn_cnt      <= btn_cnt_n;
      diag         <= diag_n;
      bits         <= bits_n;
      have_digit   <= have_digit_n;
      wiring_valid <= emit_wiring;
      end_of_line  <= emit_eol;
      parse_error  <= parse_error | err;
      end_of_file  <= end_of_file | inbound_eof;
      if (emit_wiring) begin
        wiring_data <= emit_data;
      end
    end
  end

endmodule

// File: tb/tb_machine_line_decoder.sv
// Bench for machine_line_decoder: directed lines with literal strobe lists, then random lines
// checked cycle by cycle against a character-level reference model.
module tb_machine_line_decoder;

  localparam int W     = 16;
  localparam int B     = 16;
  localparam int NEVER = 32'h7fffffff;

  localparam int MS_START = 0;
  localparam int MS_DIAG  = 1;
  localparam int MS_GAP   = 2;
  localparam int MS_BTN   = 3;
  localparam int MS_JOLT  = 4;
  localparam int MS_SKIP  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inbound_valid = 1'b0;
  logic [7:0]    inbound_data = 8'h00;
  logic          inbound_eof = 1'b0;
  logic          end_of_file;
  logic          end_of_line;
  logic          wiring_valid;
  logic [W-1:0]  wiring_data;
  logic          parse_error;

  machine_line_decoder #(
    .MAX_WIRING_WIDTH   (W),
    .MAX_BUTTON_WIRINGS (B)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inbound_valid (inbound_valid),
    .inbound_data  (inbound_data),
    .inbound_eof   (inbound_eof),
    .end_of_file   (end_of_file),
    .end_of_line   (end_of_line),
    .wiring_valid  (wiring_valid),
    .wiring_data   (wiring_data),
    .parse_error   (parse_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           cyc;
    bit           eol;
    logic [W-1:0] dat;
  } ev_t;

  ev_t          exp_q[$];
  int           m_mode, m_nl, m_cur, m_groups;
  logic [W-1:0] m_lights, m_gbits, m_last;
  int           m_err_cyc, m_eof_cyc;
  bit           m_eof;

  task automatic model_reset();
    exp_q.delete();
    m_mode = MS_START; m_nl = 0; m_cur = -1; m_groups = 0;
    m_lights = '0; m_gbits = '0; m_last = '0;
    m_err_cyc = NEVER; m_eof_cyc = NEVER; m_eof = 0;
  endtask

  task automatic push_ev(input int c, input bit eol, input logic [W-1:0] d);
    ev_t e;
    e.cyc = c; e.eol = eol; e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    bit bad;
    bad = 0;
    if (m_eof || b == 8'h0D) return;
    case (m_mode)
      MS_START: begin
        if (b == "[") begin m_mode = MS_DIAG; m_nl = 0; m_lights = '0; m_groups = 0; end
        else if (b != 8'h0A) bad = 1;
      end
      MS_DIAG: begin
        if (b == "." || b == "#") begin
          if (m_nl >= W) bad = 1;
          else begin
            if (b == "#") m_lights[m_nl] = 1'b1;
            m_nl++;
          end
        end else if (b == "]") begin
          push_ev(c + 1, 0, m_lights);
          m_mode = MS_GAP;
        end else bad = 1;
      end
      MS_GAP: begin
        if (b == "(") begin
          if (m_groups >= B) bad = 1;
          else begin m_mode = MS_BTN; m_cur = -1; m_gbits = '0; end
        end else if (b == "{") m_mode = MS_JOLT;
        else if (b == 8'h0A) begin push_ev(c + 1, 1, '0); m_mode = MS_START; end
        else if (b != " ") bad = 1;
      end
      MS_BTN: begin
        if (b >= "0" && b <= "9") begin
          if (m_cur < 0) m_cur = 0;
          if (m_cur < 100000) m_cur = m_cur * 10 + int'(b - "0");
        end else if (b == "," || b == ")") begin
          if (m_cur < 0 || m_cur >= W) bad = 1;
          else begin
            m_gbits[m_cur] = 1'b1;
            m_cur = -1;
            if (b == ")") begin
              push_ev(c + 1, 0, m_gbits);
              m_groups++;
              m_mode = MS_GAP;
            end
          end
        end else bad = 1;
      end
      MS_JOLT: if (b == "}") m_mode = MS_GAP;
      default: if (b == 8'h0A) m_mode = MS_START;
    endcase
    if (bad) begin
      if (m_err_cyc == NEVER) m_err_cyc = c + 1;
      m_mode = (b == 8'h0A) ? MS_START : MS_SKIP;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [16:0]  dut_log[$];
  logic [16:0]  lit_q[$];
  bit           c_ew, c_ee;

  always @(negedge clk) begin
    if (rst_n) begin
      c_ew = 0; c_ee = 0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        c_ee = exp_q[0].eol;
        c_ew = !exp_q[0].eol;
        if (c_ew) m_last = exp_q[0].dat;
        void'(exp_q.pop_front());
      end
      chk("wiring_valid", 32'(wiring_valid), 32'(c_ew));
      chk("end_of_line", 32'(end_of_line), 32'(c_ee));
      chk("wiring_data", 32'(wiring_data), 32'(m_last));
      chk("parse_error", 32'(parse_error), 32'(cyc >= m_err_cyc));
      chk("end_of_file", 32'(end_of_file), 32'(cyc >= m_eof_cyc));
      if (wiring_valid) dut_log.push_back({1'b0, wiring_data});
      if (end_of_line) dut_log.push_back({1'b1, 16'h0000});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input bit eof);
    @(posedge clk); #1;
    inbound_valid = 1'b1;
    inbound_data  = b;
    inbound_eof   = eof;
    model_byte(b, cyc);
    if (eof && !m_eof) begin
      m_eof = 1;
      m_eof_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      inbound_valid = 1'b0;
      inbound_eof   = 1'b0;
      inbound_data  = 8'h00;
    end
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      send_byte(s[i], 1'b0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    inbound_valid = 1'b0;
    inbound_eof = 1'b0;
    model_reset();
    #3;
    chk("rst_wiring_valid", 32'(wiring_valid), 0);
    chk("rst_end_of_line", 32'(end_of_line), 0);
    chk("rst_wiring_data", 32'(wiring_data), 0);
    chk("rst_parse_error", 32'(parse_error), 0);
    chk("rst_end_of_file", 32'(end_of_file), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic expect_log(input string name);
    chk({name, "_count"}, 32'(dut_log.size()), 32'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < dut_log.size(); i++)
      chk({name, "_strobe"}, 32'(dut_log[i]), 32'(lit_q[i]));
    dut_log.delete();
  endtask

  function automatic string gen_line();
    string s, c;
    int dl, n, k, v;
    if ($urandom_range(0, 9) == 0) begin
      s = ($urandom_range(0, 1) != 0) ? "\r\n" : "\n";
      return s;
    end
    dl = ($urandom_range(0, 29) == 0) ? 17 : $urandom_range(1, 16);
    s = "[";
    for (int i = 0; i < dl; i++) begin
      c = ($urandom_range(0, 1) != 0) ? "#" : ".";
      s = {s, c};
    end
    s = {s, "]"};
    n = ($urandom_range(0, 29) == 0) ? 17 : $urandom_range(0, 6);
    for (int g = 0; g < n; g++) begin
      s = {s, " ("};
      k = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        v = ($urandom_range(0, 19) == 0) ? $urandom_range(16, 300) : $urandom_range(0, 15);
        if (j > 0) s = {s, ","};
        s = {s, $sformatf("%0d", v)};
      end
      s = {s, ")"};
    end
    if ($urandom_range(0, 1) != 0) s = {s, " {3,5,4,7}"};
    if ($urandom_range(0, 3) == 0) s = {s, "\r"};
    s = {s, "\n"};
    if ($urandom_range(0, 29) == 0) s.putc($urandom_range(0, s.len() - 2), "x");
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    string tail;
    model_reset();
    idle(2);
    chk("reset_wiring_valid", 32'(wiring_valid), 0);
    chk("reset_wiring_data", 32'(wiring_data), 0);
    chk("reset_parse_error", 32'(parse_error), 0);
    chk("reset_end_of_file", 32'(end_of_file), 0);
    rst_n = 1'b1;
    idle(2);

    send_str("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 0);
    idle(3);
    lit_q = '{17'h00006, 17'h00008, 17'h0000A, 17'h00004, 17'h0000C, 17'h00005, 17'h00003, 17'h10000};
    expect_log("line1");
    chk("line1_parse_error", 32'(parse_error), 0);

    send_str("[#.........#.] (10,12) (0)\r\n", 1);
    idle(3);
    lit_q = '{17'h00401, 17'h01400, 17'h00001, 17'h10000};
    expect_log("line_cr");

    send_str("\n\n[#.#] (1)\n", 0);
    idle(3);
    lit_q = '{17'h00005, 17'h00002, 17'h10000};
    expect_log("blank_lines");

    send_str("[...] (16) (1)\n", 0);
    idle(3);
    lit_q = '{17'h00000};
    expect_log("bad_index");
    chk("bad_index_parse_error", 32'(parse_error), 1);
    send_str("[##] (0,1)\n", 0);
    idle(3);
    lit_q = '{17'h00003, 17'h00003, 17'h10000};
    expect_log("after_error");

    send_str("[##] (0", 0);
    do_reset();
    idle(3);
    lit_q.delete();
    dut_log.delete();
    send_str("[#] (0)\n", 0);
    idle(3);
    lit_q = '{17'h00001, 17'h00001, 17'h10000};
    expect_log("after_reset");

    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_str(gen_line(), 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("random_queue_drained", 32'(exp_q.size()), 0);

    do_reset();
    dut_log.delete();
    send_str("[#] (0)\n[##] (1)", 0);
    idle(1);
    @(negedge clk);
    chk("eof_before", 32'(end_of_file), 0);
    send_byte(8'h0A, 1'b1);
    @(posedge clk); #1;
    inbound_valid = 1'b0;
    inbound_eof = 1'b0;
    @(negedge clk);
    chk("eof_with_eol", 32'({end_of_line, end_of_file}), 32'h3);
    idle(2);
    lit_q = '{17'h00001, 17'h00001, 17'h10000, 17'h00003, 17'h00002, 17'h10000};
    expect_log("two_lines_eof");
    tail = "[#] (0)\n";
    send_str(tail, 0);
    idle(3);
    lit_q.delete();
    expect_log("after_eof");
    chk("eof_sticky", 32'(end_of_file), 1);
    chk("final_queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
